// File: rtl/boreal_cursor_tx.sv
// boreal_cursor_tx: decimates mu_x/mu_y estimates into 7-byte checksummed frames on a byte stream
module boreal_cursor_tx #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [15:0] DECIM     = 16'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mu_valid,
  input  logic [15:0] mu_x,
  input  logic [15:0] mu_y,
  input  logic        emergency_halt,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic [15:0] drop_count
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] hdr_q, hdr_d;
  logic [31:0] smp_q, smp_d, pend_q, pend_d;
  logic pend_full_q, pend_full_d;
  logic [15:0] cnt_q, cnt_d, drop_q, drop_d;
  logic [6:0] seq_q, seq_d;
  logic halt_flag_q, halt_flag_d, halt_prev_q;
  logic halt_edge, trigger, hs, last, launch_new, launch_pend, dropping, in_send;
  logic [7:0] chk;
  logic [7:0] frame [8];
  assign in_send = state_q == SEND;
  assign tx_valid = in_send;
  assign busy = in_send;
  assign drop_count = drop_q;
  assign halt_edge = emergency_halt & ~halt_prev_q;
  assign trigger = halt_edge | (mu_valid & (cnt_q == DECIM - 16'd1));
  assign hs = in_send & tx_ready;
  assign last = hs & (idx_q == 3'd6);
  assign launch_new = trigger & (~in_send | last);
  assign launch_pend = last & ~trigger & pend_full_q;
  // a trigger that is neither launched nor parked in an empty slot displaces something
  assign dropping = pend_full_q & trigger & in_send;
  assign chk = hdr_q ^ smp_q[31:24] ^ smp_q[23:16] ^ smp_q[15:8] ^ smp_q[7:0];
  assign frame = '{SYNC_BYTE, hdr_q, smp_q[31:24], smp_q[23:16], smp_q[15:8], smp_q[7:0], chk, 8'h00};
  assign tx_data = in_send ? frame[idx_q] : 8'h00;
  always_comb begin
    state_d = state_q;
    idx_d = hs ? idx_q + 3'd1 : idx_q;
    hdr_d = hdr_q;
    smp_d = smp_q;
    pend_d = pend_q;
    pend_full_d = pend_full_q;
    seq_d = seq_q;
    halt_flag_d = halt_flag_q | halt_edge;
    cnt_d = halt_edge ? 16'd0 : mu_valid ? ((cnt_q == DECIM - 16'd1) ? 16'd0 : cnt_q + 16'd1) : cnt_q;
    drop_d = (dropping && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    if (launch_new || launch_pend) begin
      state_d = SEND;
      idx_d = 3'd0;
      hdr_d = {seq_q, halt_flag_q | halt_edge};
      smp_d = launch_new ? {mu_x, mu_y} : pend_q;
      seq_d = seq_q + 7'd1;
      halt_flag_d = 1'b0;
      pend_full_d = 1'b0;
    end else if (last) begin
      state_d = IDLE;
    end else if (trigger && in_send) begin
      pend_d = {mu_x, mu_y};
      pend_full_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= 3'd0;
      hdr_q <= 8'h00;
      smp_q <= 32'h0;
      pend_q <= 32'h0;
      pend_full_q <= 1'b0;
      seq_q <= 7'd0;
      halt_flag_q <= 1'b0;
      halt_prev_q <= 1'b0;
      cnt_q <= 16'd0;
      drop_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      hdr_q <= hdr_d;
      smp_q <= smp_d;
      pend_q <= pend_d;
      pend_full_q <= pend_full_d;
      seq_q <= seq_d;
      halt_flag_q <= halt_flag_d;
      halt_prev_q <= emergency_halt;
      cnt_q <= cnt_d;
      drop_q <= drop_d;
    end
  end
endmodule
